// File: rtl/reg_file_scan.sv
// Parametrised register file with two bypassable read ports, a dedicated PC
// write path, and a snapshot dump engine streaming all registers over valid/ready.
module reg_file_scan #(
  parameter int                DATA_W    = 16,
  parameter int                ADDR_W    = 3,
  parameter int                PC_REG    = 0,
  parameter logic [DATA_W-1:0] RESET_VAL = '1,
  parameter bit                BYPASS    = 1'b1
) (
  input  logic              clk,
  input  logic              proc_rst,
  input  logic [ADDR_W-1:0] ra,
  input  logic [ADDR_W-1:0] rb,
  output logic [DATA_W-1:0] ra_data,
  output logic [DATA_W-1:0] rb_data,
  input  logic              reg_write,
  input  logic [ADDR_W-1:0] rc,
  input  logic [DATA_W-1:0] rc_data,
  input  logic              pc_write,
  input  logic [DATA_W-1:0] pc_in,
  output logic [DATA_W-1:0] pc_out,
  input  logic              dump_start,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [ADDR_W-1:0] dump_idx,
  output logic [DATA_W-1:0] dump_data,
  output logic              dump_busy,
  output logic              dump_done
);
  localparam int                NUM_REGS = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS-1);

  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

  logic [NUM_REGS-1:0][DATA_W-1:0] regs, snap, wr_val;
  logic [NUM_REGS-1:0]             wr_en;
  state_t                          state;

  // Per-register winning write: on the PC register pc_in beats rc_data.
  for (genvar i = 0; i < NUM_REGS; i++) begin : g_wr
    if (i == PC_REG) begin : g_pc
      assign wr_en[i]  = !proc_rst && (pc_write || (reg_write && rc == ADDR_W'(i)));
      assign wr_val[i] = pc_write ? pc_in : rc_data;
    end else begin : g_gpr
      assign wr_en[i]  = !proc_rst && reg_write && rc == ADDR_W'(i);
      assign wr_val[i] = rc_data;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REGS; i++) begin
      if (proc_rst)      regs[i] <= RESET_VAL;
      else if (wr_en[i]) regs[i] <= wr_val[i];
    end
  end

  assign ra_data   = (BYPASS && wr_en[ra]) ? wr_val[ra] : regs[ra];
  assign rb_data   = (BYPASS && wr_en[rb]) ? wr_val[rb] : regs[rb];
  assign pc_out    = regs[PC_REG];
  assign dump_data = snap[dump_idx];

  // Snapshot captures pre-edge contents, so live writes never leak into a dump.
  always_ff @(posedge clk) begin
    if (proc_rst) begin
      state      <= IDLE;
      dump_idx   <= '0;
      dump_valid <= 1'b0;
      dump_busy  <= 1'b0;
      dump_done  <= 1'b0;
      snap       <= {NUM_REGS{RESET_VAL}};
    end else begin
      case (state)
        IDLE: begin
          dump_done <= 1'b0;
          if (dump_start) begin
            snap       <= regs;
            dump_idx   <= '0;
            dump_valid <= 1'b1;
            dump_busy  <= 1'b1;
            state      <= SEND;
          end
        end
        SEND: begin
          if (dump_ready) begin
            if (dump_idx != LAST_IDX) begin
              dump_idx <= dump_idx + ADDR_W'(1);
            end else begin
              dump_valid <= 1'b0;
              dump_busy  <= 1'b0;
              dump_done  <= 1'b1;
              state      <= DONE;
            end
          end
        end
        DONE: begin
          dump_done <= 1'b0;
          dump_idx  <= '0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_reg_file_scan.sv
// Randomised self-checking bench for reg_file_scan; runs a bypassing and a
// non-bypassing instance side by side against an array-based reference.
module tb_reg_file_scan;
  logic        clk = 1'b0;
  logic        proc_rst = 1'b1;
  logic [2:0]  ra = '0, rb = '0, rc = '0;
  logic        reg_write = 1'b0, pc_write = 1'b0;
  logic [15:0] rc_data = '0, pc_in = '0;
  logic        dump_start = 1'b0, dump_ready = 1'b0;

  logic [15:0] ra_data1, rb_data1, pc_out1, dump_data1;
  logic [15:0] ra_data0, rb_data0, pc_out0, dump_data0;
  logic [2:0]  dump_idx1, dump_idx0;
  logic        dump_valid1, dump_busy1, dump_done1;
  logic        dump_valid0, dump_busy0, dump_done0;

  int vectors = 0, miscompares = 0;
  logic [15:0] m [8];

  always #5 clk = ~clk;

  reg_file_scan #(.BYPASS(1'b1)) dut1 (
    .clk(clk), .proc_rst(proc_rst), .ra(ra), .rb(rb), .ra_data(ra_data1), .rb_data(rb_data1),
    .reg_write(reg_write), .rc(rc), .rc_data(rc_data), .pc_write(pc_write), .pc_in(pc_in),
    .pc_out(pc_out1), .dump_start(dump_start), .dump_valid(dump_valid1), .dump_ready(dump_ready),
    .dump_idx(dump_idx1), .dump_data(dump_data1), .dump_busy(dump_busy1), .dump_done(dump_done1));

  reg_file_scan #(.BYPASS(1'b0)) dut0 (
    .clk(clk), .proc_rst(proc_rst), .ra(ra), .rb(rb), .ra_data(ra_data0), .rb_data(rb_data0),
    .reg_write(reg_write), .rc(rc), .rc_data(rc_data), .pc_write(pc_write), .pc_in(pc_in),
    .pc_out(pc_out0), .dump_start(dump_start), .dump_valid(dump_valid0), .dump_ready(dump_ready),
    .dump_idx(dump_idx0), .dump_data(dump_data0), .dump_busy(dump_busy0), .dump_done(dump_done0));

  // Reference: apply the general write, then let the PC write overwrite R0.
  task automatic tick();
    logic [15:0] nx [8];
    nx = m;
    if (proc_rst) begin
      for (int i = 0; i < 8; i++) nx[i] = 16'hFFFF;
    end else begin
      if (reg_write) nx[rc] = rc_data;
      if (pc_write)  nx[0]  = pc_in;
    end
    @(posedge clk);
    #1;
    m = nx;
  endtask

  function automatic logic [15:0] exp_read(input logic [2:0] a, input bit byp);
    if (byp && !proc_rst) begin
      if (pc_write && a == 3'd0) return pc_in;
      if (reg_write && rc == a)  return rc_data;
    end
    return m[a];
  endfunction

  task automatic idle_inputs();
    reg_write = 1'b0; pc_write = 1'b0; dump_start = 1'b0;
  endtask

  task automatic load_ramp();
    for (int i = 0; i < 8; i++) begin
      reg_write = 1'b1; rc = 3'(i); rc_data = 16'(i) * 16'h0101;
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_reset();
    proc_rst = 1'b1;
    tick();
    proc_rst = 1'b0;
    for (int a = 0; a < 8; a++) begin
      ra = 3'(a); rb = 3'(7 - a);
      #1;
      vectors++; if (ra_data1 !== 16'hFFFF) begin miscompares++; $display("FAIL reset_ra r%0d got %h want ffff", a, ra_data1); end
      vectors++; if (rb_data0 !== 16'hFFFF) begin miscompares++; $display("FAIL reset_rb r%0d got %h want ffff", 7 - a, rb_data0); end
    end
    vectors++; if (pc_out1 !== 16'hFFFF) begin miscompares++; $display("FAIL reset_pc got %h want ffff", pc_out1); end
    vectors++; if ({dump_valid1, dump_busy1, dump_done1, dump_valid0} !== 4'b0) begin miscompares++;
      $display("FAIL reset_dump_flags got %b want 0000", {dump_valid1, dump_busy1, dump_done1, dump_valid0}); end
    vectors++; if (dump_idx1 !== 3'd0 || dump_data1 !== 16'hFFFF) begin miscompares++;
      $display("FAIL reset_dump_out got idx %0d data %h want 0 ffff", dump_idx1, dump_data1); end
  endtask

  task automatic test_concurrent();
    pc_write = 1'b1; pc_in = 16'h0010; reg_write = 1'b1; rc = 3'd3; rc_data = 16'h1234;
    tick();
    idle_inputs(); ra = 3'd0; rb = 3'd3;
    #1;
    vectors++; if (ra_data0 !== 16'h0010 || pc_out1 !== 16'h0010) begin miscompares++;
      $display("FAIL concurrent_pc got %h/%h want 0010", ra_data0, pc_out1); end
    vectors++; if (rb_data0 !== 16'h1234) begin miscompares++; $display("FAIL concurrent_r3 got %h want 1234", rb_data0); end
    pc_write = 1'b1; pc_in = 16'h0020; reg_write = 1'b1; rc = 3'd0; rc_data = 16'hBEEF;
    #1;
    vectors++; if (ra_data1 !== 16'h0020) begin miscompares++; $display("FAIL conflict_bypass got %h want 0020", ra_data1); end
    tick();
    idle_inputs();
    #1;
    vectors++; if (pc_out1 !== 16'h0020 || ra_data0 !== 16'h0020) begin miscompares++;
      $display("FAIL conflict_pc_wins got %h/%h want 0020", pc_out1, ra_data0); end
  endtask

  task automatic test_bypass();
    logic [15:0] old5;
    old5 = m[5];
    reg_write = 1'b1; rc = 3'd5; rc_data = 16'hA5A5; ra = 3'd5;
    #1;
    vectors++; if (ra_data1 !== 16'hA5A5) begin miscompares++; $display("FAIL bypass_on got %h want a5a5", ra_data1); end
    vectors++; if (ra_data0 !== old5) begin miscompares++; $display("FAIL bypass_off got %h want %h", ra_data0, old5); end
    tick();
    idle_inputs();
    #1;
    vectors++; if (ra_data0 !== 16'hA5A5) begin miscompares++; $display("FAIL bypass_off_next got %h want a5a5", ra_data0); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      ra = 3'($urandom); rb = 3'($urandom); rc = 3'($urandom);
      reg_write = 1'($urandom); pc_write = ($urandom_range(0, 3) == 0);
      rc_data = 16'($urandom); pc_in = 16'($urandom);
      #1;
      vectors++; if (ra_data1 !== exp_read(ra, 1'b1)) begin miscompares++;
        $display("FAIL rand_ra_byp r%0d got %h want %h", ra, ra_data1, exp_read(ra, 1'b1)); end
      vectors++; if (rb_data1 !== exp_read(rb, 1'b1)) begin miscompares++;
        $display("FAIL rand_rb_byp r%0d got %h want %h", rb, rb_data1, exp_read(rb, 1'b1)); end
      vectors++; if (ra_data0 !== exp_read(ra, 1'b0)) begin miscompares++;
        $display("FAIL rand_ra_nobyp r%0d got %h want %h", ra, ra_data0, exp_read(ra, 1'b0)); end
      vectors++; if (pc_out1 !== m[0]) begin miscompares++; $display("FAIL rand_pc got %h want %h", pc_out1, m[0]); end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_dump();
    logic [15:0] s [8];
    load_ramp();
    s = m;
    dump_ready = 1'b1; dump_start = 1'b1;
    tick();
    dump_start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      #1;
      vectors++; if (dump_valid1 !== 1'b1 || dump_busy1 !== 1'b1 || dump_done1 !== 1'b0 || dump_idx1 !== 3'(k) || dump_data1 !== s[k]) begin
        miscompares++; $display("FAIL dump_beat%0d got v%b b%b d%b idx %0d data %h want v1 b1 d0 idx %0d data %h",
          k, dump_valid1, dump_busy1, dump_done1, dump_idx1, dump_data1, k, s[k]); end
      tick();
    end
    vectors++; if (dump_done1 !== 1'b1 || dump_valid1 !== 1'b0 || dump_busy1 !== 1'b0) begin miscompares++;
      $display("FAIL dump_done got d%b v%b b%b want d1 v0 b0", dump_done1, dump_valid1, dump_busy1); end
    tick();
    vectors++; if (dump_done1 !== 1'b0 || dump_valid1 !== 1'b0) begin miscompares++;
      $display("FAIL dump_done_width got d%b v%b want d0 v0", dump_done1, dump_valid1); end
  endtask

  task automatic test_backpressure();
    logic [15:0] s [8];
    int beats = 0;
    bit got_done = 1'b0;
    for (int i = 0; i < 8; i++) begin
      reg_write = 1'b1; rc = 3'(i); rc_data = (i == 2) ? 16'h2222 : 16'($urandom);
      tick();
    end
    idle_inputs();
    s = m;
    dump_start = 1'b1; dump_ready = 1'b0;
    tick();
    for (int cyc = 0; cyc < 60 && !got_done; cyc++) begin
      dump_ready = (cyc % 2 == 1);
      dump_start = (cyc == 3);
      reg_write  = 1'b1;
      rc         = (cyc == 1) ? 3'd2 : 3'($urandom);
      rc_data    = (cyc == 1) ? 16'hFFFF : 16'($urandom);
      pc_write   = 1'($urandom);
      pc_in      = 16'($urandom);
      #1;
      if (dump_done1) begin
        got_done = 1'b1;
        vectors++; if (beats !== 8) begin miscompares++; $display("FAIL bp_beat_count got %0d want 8", beats); end
      end else begin
        vectors++; if (dump_valid1 !== 1'b1 || dump_idx1 !== 3'(beats) || dump_data1 !== s[beats]) begin miscompares++;
          $display("FAIL bp_beat cyc %0d got v%b idx %0d data %h want v1 idx %0d data %h",
            cyc, dump_valid1, dump_idx1, dump_data1, beats, s[beats]); end
        if (dump_valid1 && dump_ready) beats++;
      end
      tick();
    end
    idle_inputs();
    vectors++; if (!got_done) begin miscompares++; $display("FAIL bp_timeout got beats %0d want done", beats); end
    for (int n = 0; n < 3; n++) begin
      #1;
      vectors++; if (dump_valid1 !== 1'b0 || dump_done1 !== 1'b0) begin miscompares++;
        $display("FAIL bp_no_restart got v%b d%b want v0 d0", dump_valid1, dump_done1); end
      tick();
    end
  endtask

  task automatic test_reset_mid_dump();
    bit got_done = 1'b0;
    load_ramp();
    dump_ready = 1'b1; dump_start = 1'b1;
    tick();
    dump_start = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    #1;
    vectors++; if (dump_idx1 !== 3'd4 || dump_valid1 !== 1'b1) begin miscompares++;
      $display("FAIL mid_pre_reset got idx %0d v%b want idx 4 v1", dump_idx1, dump_valid1); end
    proc_rst = 1'b1;
    tick();
    proc_rst = 1'b0;
    #1;
    vectors++; if (dump_valid1 !== 1'b0 || dump_busy1 !== 1'b0 || dump_done1 !== 1'b0 || dump_idx1 !== 3'd0 || dump_data1 !== 16'hFFFF) begin
      miscompares++; $display("FAIL mid_reset got v%b b%b d%b idx %0d data %h want v0 b0 d0 idx 0 data ffff",
        dump_valid1, dump_busy1, dump_done1, dump_idx1, dump_data1); end
    for (int n = 0; n < 10; n++) begin
      if (dump_done1 || dump_valid1) got_done = 1'b1;
      tick();
    end
    vectors++; if (got_done) begin miscompares++; $display("FAIL mid_reset_no_done got activity want none"); end
    dump_start = 1'b1;
    tick();
    dump_start = 1'b0;
    #1;
    vectors++; if (dump_valid1 !== 1'b1 || dump_idx1 !== 3'd0 || dump_data1 !== m[0]) begin miscompares++;
      $display("FAIL restart got v%b idx %0d data %h want v1 idx 0 data %h", dump_valid1, dump_idx1, dump_data1, m[0]); end
    got_done = 1'b0;
    for (int n = 0; n < 20 && !got_done; n++) begin
      tick();
      if (dump_done1) got_done = 1'b1;
    end
    vectors++; if (!got_done) begin miscompares++; $display("FAIL restart_timeout got no done want done"); end
  endtask

  initial begin
    test_reset();
    test_concurrent();
    test_bypass();
    test_random();
    test_dump();
    test_backpressure();
    test_reset_mid_dump();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/reg_file_scan.md
# reg_file_scan

Parametrised successor of the processor's 16-bit, 8-entry register file. It keeps two combinational read ports, one general write port and a dedicated PC write path into register `PC_REG`. It adds a configurable write-to-read bypass and concurrent PC/GPR writes. It also adds a snapshot dump engine that streams every register over a valid/ready channel for debug and trace, without stalling the datapath.

## Interface
Parameters:
- `DATA_W`, 16, register width.
- `ADDR_W`, 3, address width; `NUM_REGS = 2**ADDR_W`.
- `PC_REG`, 0, index of the register that acts as the program counter.
- `RESET_VAL`, all ones (16'hFFFF at default width), value loaded into every register and snapshot entry on reset.
- `BYPASS`, 1; 1 = same-cycle write data forwarded to read ports, 0 = reads return array contents only.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  clock; all state updates on the rising edge.
- `proc_rst`  in  1  synchronous active-high reset.
- `ra`  in  ADDR_W  read port A address.
- `rb`  in  ADDR_W  read port B address.
- `ra_data`  out  DATA_W  read port A data.
- `rb_data`  out  DATA_W  read port B data.
- `reg_write`  in  1  general write enable.
- `rc`  in  ADDR_W  general write address.
- `rc_data`  in  DATA_W  general write data.
- `pc_write`  in  1  PC write enable, targets `PC_REG`.
- `pc_in`  in  DATA_W  PC write data.
- `pc_out`  out  DATA_W  current contents of `PC_REG`.
- `dump_start`  in  1  request a full-register dump; sampled only in IDLE.
- `dump_valid`  out  1  dump beat valid.
- `dump_ready`  in  1  consumer accepts beat.
- `dump_idx`  out  ADDR_W  register index of the current beat.
- `dump_data`  out  DATA_W  snapshot value of register `dump_idx`.
- `dump_busy`  out  1  high while the FSM is in SEND.
- `dump_done`  out  1  one-cycle pulse after the last beat is accepted.

## Operation
- Write arbitration, per edge when not in reset:
  - If `pc_write` is high, `PC_REG` ← `pc_in`.
  - If `reg_write` is high and `rc` != `PC_REG`, `reg[rc]` ← `rc_data`.
  - If `reg_write` is high, `rc` == `PC_REG` and `pc_write` is also high, `pc_in` wins and `rc_data` is dropped.
  - If `reg_write` is high, `rc` == `PC_REG` and `pc_write` is low, `PC_REG` ← `rc_data`.
  - Both writes can complete in the same cycle when they target different registers.
- Read ports are combinational.
  - With `BYPASS`=1, each port returns the value that will be written at the next edge, using the arbitration above, when its address matches a winning write. Otherwise it returns array contents.
  - With `BYPASS`=0, each port returns array contents only.
- `pc_out` = array `PC_REG` and is never bypassed.
- Dump FSM states:
  - IDLE → SEND when `dump_start` = 1. On that edge every register is copied into the snapshot, using values from before that edge's writes; `dump_idx` ← 0.
  - SEND: `dump_valid` = 1 and `dump_data` = `snapshot[dump_idx]`. On `dump_valid && dump_ready`:
    - if `dump_idx` != `NUM_REGS`-1, `dump_idx` increments;
    - otherwise the FSM goes to DONE.
  - DONE: `dump_done` = 1 for one cycle, then IDLE with `dump_idx` ← 0.
- `dump_start` is ignored in SEND and DONE; there is no queuing.
- Register writes continue normally during a dump. The snapshot is not affected by them.

## Timing
- Reset, on an edge with `proc_rst` = 1:
  - all registers and snapshot entries = `RESET_VAL`;
  - FSM = IDLE, `dump_idx` = 0, `dump_valid` = 0, `dump_busy` = 0, `dump_done` = 0;
  - `pc_out` = `RESET_VAL`, and `dump_data` = `RESET_VAL`.
- Reset overrides any write or dump in the same cycle. Reset mid-dump aborts it: `dump_valid` drops on the next cycle and no `dump_done` pulse is produced.
- Write latency: the array updates one edge after enables are sampled. The bypassed read sees the new value in the same cycle (`BYPASS`=1).
- Dump latency: the first beat is valid in the cycle after the `dump_start` edge.
  - With `dump_ready` held high, beats run one per cycle for `NUM_REGS` cycles, followed by one `dump_done` cycle. The earliest next start is the cycle after `dump_done`.
- Stall: while `dump_valid && !dump_ready`, both `dump_idx` and `dump_data` hold stable.
- `dump_idx` never wraps within a dump; the last index is `NUM_REGS`-1.

## Test plan
- Reset: assert `proc_rst` for 1 cycle → all 8 reads = 16'hFFFF, `pc_out` = 16'hFFFF, `dump_valid` = 0, `dump_busy` = 0.
- Concurrent write: `pc_write` = 1 with `pc_in` = 16'h0010, plus `reg_write` = 1 with `rc` = 3 and `rc_data` = 16'h1234 → next cycle R0 = 0010 and R3 = 1234. Repeat with `rc` = 0 and `rc_data` = 16'hBEEF → R0 = `pc_in`, BEEF dropped.
- Bypass: `BYPASS`=1, `reg_write` = 1, `rc` = 5, `rc_data` = 16'hA5A5, `ra` = 5 → `ra_data` = A5A5 in the same cycle. With `BYPASS`=0 → `ra_data` = old R5 until the next cycle.
- Dump, ready always high, with R*i* = *i*·16'h0101 → 8 consecutive beats with `dump_idx` 0..7 and data 0000, 0101, …, 0707, then `dump_done` for exactly 1 cycle.
- Dump with backpressure and live writes: toggle `dump_ready` 1/0 and write R2 = 16'hFFFF mid-dump → idx/data stable during stalls; beat 2 carries the snapshot value, not FFFF. A `dump_start` pulse while busy has no effect.
- Reset mid-dump after beat 3 → `dump_valid` = 0 next cycle, `dump_idx` = 0, no `dump_done`. A new `dump_start` then restarts at idx 0.
